// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage controller splitting 32-bit loads/stores into two 16-bit SRAM half-word accesses.
// Define SRAM_WAIT_EN to stretch each half-word phase to two cycles.
module mem_stage_sram_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_res,
  input  logic [31:0] val_rm,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e      state_q, state_d;
  logic        is_write_q, is_write_d;
  logic [16:0] idx_q, idx_d;
  logic [31:0] val_q, val_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req;
  logic [16:0] word_idx;
  logic        phase_end;

  assign req = mem_read | mem_write;

  // Data memory starts at byte 1024; the low two address bits never borrow, so slicing first is
  // equivalent to (alu_res - 1024)[18:2] with modulo-2^17 wrap.
  assign word_idx = alu_res[18:2] - 17'd256;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{alu_res[31:19], alu_res[1:0]};

`ifdef SRAM_WAIT_EN
  logic wait_q, wait_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign phase_end = wait_q;
`else
  assign phase_end = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    val_d      = val_q;
    rdata_d    = rdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          state_d    = StLo;
          is_write_d = mem_write;
          idx_d      = word_idx;
          val_d      = val_rm;
        end
      end
      StLo: begin
        if (phase_end) begin
          state_d = StHi;
          if (!is_write_q) rdata_d[15:0] = sram_dq_in;
        end
      end
      StHi: begin
        if (phase_end) begin
          state_d = StDone;
          if (!is_write_q) rdata_d[31:16] = sram_dq_in;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef SRAM_WAIT_EN
    // Counter restarts whenever a phase is entered and only advances while a phase is held.
    wait_d = 1'b0;
    if ((state_d == state_q) && ((state_q == StLo) || (state_q == StHi))) begin
      wait_d = ~wait_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      val_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      val_q      <= val_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    ready       = 1'b0;
    case (state_q)
      StIdle: ready = ~req;
      StLo: begin
        sram_addr = {idx_q, 1'b0};
        if (is_write_q) begin
          sram_dq_out = val_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      StHi: begin
        sram_addr = {idx_q, 1'b1};
        if (is_write_q) begin
          sram_dq_out = val_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      StDone:  ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Bench for mem_stage_sram_ctrl: directed scenarios plus random traffic checked every cycle
// against a transaction-level model that schedules each access's expected cycles.
module tb_mem_stage_sram_ctrl;

`ifdef SRAM_WAIT_EN
  localparam int PH = 2;
`else
  localparam int PH = 1;
`endif
  localparam int N = 2 + 2 * PH;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] alu_res, val_rm;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic [15:0] sram_dq_in;

  int checks = 0;
  int errors = 0;

  mem_stage_sram_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .alu_res    (alu_res),
    .val_rm     (val_rm),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_dq_in (sram_dq_in)
  );

  always #5 clk = ~clk;

  // SRAM model: 1024 half-words, aliased on the low address bits.
  logic [15:0] mem [0:1023];
  logic        mem_init;
  assign sram_dq_in = mem[sram_addr[9:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'(i * 40503 + 12345);
    end else if (!sram_we_n) begin
      mem[sram_addr[9:0]] <= sram_dq_out;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        rdy;
    logic [17:0] addr;
    logic        oe;
    logic        we_n;
    logic [15:0] dq;
    logic [1:0]  smp;
  } exp_t;

  exp_t        sched[$];
  logic [31:0] m_rdata = '0;

  // Each accepted access expands into its full expected cycle sequence.
  always @(negedge clk) begin
    exp_t        e;
    logic [16:0] idx;
    logic [36:0] act, want;
    logic        req;
    req = mem_read | mem_write;
    if (rst) begin
      sched.delete();
      m_rdata = '0;
      e = '{rdy: ~req, addr: '0, oe: 1'b0, we_n: 1'b1, dq: '0, smp: 2'd0};
    end else if (sched.size() != 0) begin
      e = sched.pop_front();
    end else begin
      e = '{rdy: ~req, addr: '0, oe: 1'b0, we_n: 1'b1, dq: '0, smp: 2'd0};
      if (req) begin
        idx = 17'((alu_res - 32'd1024) >> 2);
        for (int p = 0; p < 2; p++) begin
          for (int c = 0; c < PH; c++) begin
            sched.push_back('{rdy: 1'b0, addr: {idx, p[0]}, oe: mem_write, we_n: ~mem_write,
                              dq: mem_write ? (p == 0 ? val_rm[15:0] : val_rm[31:16]) : 16'h0,
                              smp: (!mem_write && c == PH - 1) ? 2'(p + 1) : 2'd0});
          end
        end
        sched.push_back('{rdy: 1'b1, addr: '0, oe: 1'b0, we_n: 1'b1, dq: '0, smp: 2'd0});
      end
    end
    act  = {ready, sram_addr, sram_dq_oe, sram_we_n, sram_dq_out};
    want = {e.rdy, e.addr, e.oe, e.we_n, e.dq};
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL outputs t=%0t actual=%h required=%h", $time, act, want);
    end
    checks++;
    if (rdata !== m_rdata) begin
      errors++;
      $display("FAIL rdata t=%0t actual=%h required=%h", $time, rdata, m_rdata);
    end
    if (e.smp == 2'd1) m_rdata[15:0] = mem[e.addr[9:0]];
    if (e.smp == 2'd2) m_rdata[31:16] = mem[e.addr[9:0]];
  end

  logic [15:0] save9;
  logic [2*N-1:0] rdy_act, rdy_exp;

  initial begin
    rst = 1'b1;
    mem_init = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    alu_res = '0;
    val_rm = '0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ready", 32'(ready), 32'h1);
    chk("rst_we_n", 32'(sram_we_n), 32'h1);
    chk("rst_oe", 32'(sram_dq_oe), 32'h0);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq", 32'(sram_dq_out), 32'h0);
    @(posedge clk); #1;
    mem_init = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0xDEADBEEF at byte 1028.
    mem_write = 1'b1; alu_res = 32'd1028; val_rm = 32'hDEADBEEF;
    @(negedge clk) chk("wr_req_ready", 32'(ready), 32'h0);
    @(posedge clk); #1;
    mem_write = 1'b0; alu_res = $urandom; val_rm = $urandom;
    for (int i = 0; i < 2 * PH; i++) begin
      @(negedge clk);
      chk("wr_addr", 32'(sram_addr), (i < PH) ? 32'd2 : 32'd3);
      chk("wr_dq", 32'(sram_dq_out), (i < PH) ? 32'hBEEF : 32'hDEAD);
      chk("wr_we_n", 32'(sram_we_n), 32'h0);
      chk("wr_ready", 32'(ready), 32'h0);
    end
    @(negedge clk) chk("wr_done_ready", 32'(ready), 32'h1);
    @(posedge clk); #1;
    chk("wr_mem2", 32'(mem[2]), 32'hBEEF);
    chk("wr_mem3", 32'(mem[3]), 32'hDEAD);

    // Read it back.
    mem_read = 1'b1; alu_res = 32'd1028;
    @(negedge clk) chk("rd_req_ready", 32'(ready), 32'h0);
    @(posedge clk); #1;
    mem_read = 1'b0;
    for (int i = 0; i < 2 * PH; i++) begin
      @(negedge clk);
      chk("rd_addr", 32'(sram_addr), (i < PH) ? 32'd2 : 32'd3);
      chk("rd_we_n", 32'(sram_we_n), 32'h1);
    end
    @(negedge clk);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    chk("rd_done_ready", 32'(ready), 32'h1);
    @(posedge clk); #1;

    // Read and write together: write wins, rdata untouched.
    mem_read = 1'b1; mem_write = 1'b1; alu_res = 32'd1036; val_rm = 32'h12345678;
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (2 * PH + 1) @(negedge clk);
    @(posedge clk); #1;
    chk("both_rdata", rdata, 32'hDEADBEEF);
    chk("both_mem6", 32'(mem[6]), 32'h5678);
    chk("both_mem7", 32'(mem[7]), 32'h1234);

    // Reset during the HI phase of a write.
    mem_write = 1'b1; alu_res = 32'd1040; val_rm = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_write = 1'b0;
    save9 = mem[9];
    repeat (PH + 1) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_we_n", 32'(sram_we_n), 32'h1);
    chk("mid_rst_oe", 32'(sram_dq_oe), 32'h0);
    chk("mid_rst_ready", 32'(ready), 32'h1);
    chk("mid_rst_addr", 32'(sram_addr), 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_mem8", 32'(mem[8]), 32'hF00D);
    chk("mid_rst_mem9", 32'(mem[9]), 32'(save9));

    // Back-to-back reads at 1024 then 1032.
    mem_read = 1'b1; alu_res = 32'd1024;
    for (int k = 0; k < 2 * N; k++) begin
      @(negedge clk);
      rdy_act[k] = ready;
      rdy_exp[k] = ((k % N) == N - 1);
      @(posedge clk); #1;
      if (k == 0) alu_res = 32'd1032;
      if (k == N) mem_read = 1'b0;
    end
    chk("b2b_ready", 32'(rdy_act), 32'(rdy_exp));
    chk("b2b_rdata", rdata, {mem[5], mem[4]});

    // Address below 1024 wraps modulo 2^17 words.
    mem_read = 1'b1; alu_res = 32'd0;
    @(posedge clk); #1;
    mem_read = 1'b0;
    @(negedge clk) chk("wrap_addr", 32'(sram_addr), 32'h3FE00);
    repeat (2 * PH) @(negedge clk);
    @(posedge clk); #1;

    // Random traffic, including mid-access input changes and occasional resets.
    repeat (600) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 149) == 0) rst = 1'b1;
      mem_read = ($urandom_range(0, 2) == 0);
      mem_write = ($urandom_range(0, 3) == 0);
      alu_res = ($urandom_range(0, 3) == 0) ? $urandom : 32'd1024 + $urandom_range(0, 2047);
      val_rm = $urandom;
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
